led_shift_sequencer: RTL and testbench
======================================

# led_shift_sequencer

Run controller for the 16-bit LED shift datapath. It latches the switch length configuration, issues the load pulse that seeds the shifter, then paces it with one-cycle step pulses from a prescaler. It counts steps and laps, and ends the run after a fixed number of laps. It sits between the board inputs (start, run-enable, abort, switches) and the shifter's load/shift-enable controls.

## Interface
Parameters:
- TICK_DIV, 4, enabled clock cycles per step pulse (≥2)
- STEPS_PER_LAP, 16, step pulses per lap (≥2, ≤16)
- LAPS, 2, laps per run (1..15)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  level; a rising edge (start=1, previous sample 0) requests a run
- run_en  in  1  level; 1 = prescaler advances, 0 = hold (pause)
- abort  in  1  synchronous; ends any active run without done
- switch  in  3  length select, sampled only on an accepted start edge
- cfg_len  out  3  latched switch value driven to the shifter
- sh_load  out  1  one-cycle pulse: shifter loads its seed pattern for cfg_len
- sh_step  out  1  one-cycle pulse: shifter advances one position
- lap_cnt  out  4  completed laps in the current run
- busy  out  1  high in LOAD, RUN and DONE
- done  out  1  one-cycle pulse on normal run completion

## Operation
- States: IDLE, LOAD, RUN, DONE. Registered Moore outputs except sh_step.
- Edge detect: start_q is registered and resets to 0. A start held high across reset release counts as an edge in the first post-reset cycle.
- IDLE:
  - start edge → LOAD next cycle.
  - cfg_len ← switch on the same edge.
  - prescaler, step_cnt and lap_cnt clear to 0.
- LOAD:
  - sh_load=1 for exactly this cycle.
  - → RUN unconditionally, unless abort.
- RUN, prescaler behaviour:
  - Increments only when run_en=1.
  - At TICK_DIV-1 with run_en=1: sh_step=1 that cycle, prescaler → 0, step_cnt+1.
  - run_en=0 freezes prescaler, step_cnt and lap_cnt. No step is lost or duplicated.
- RUN, lap and run completion:
  - A step with step_cnt=STEPS_PER_LAP-1 sets step_cnt → 0 and lap_cnt+1.
  - If that step completes lap LAPS-1, the next state is DONE and lap_cnt shows LAPS in DONE.
- DONE: done=1 for one cycle, → IDLE. lap_cnt and cfg_len hold until the next accepted start.
- Start edges while busy are ignored, and cfg_len does not change.
- abort=1 in LOAD, RUN or DONE:
  - → IDLE next cycle; done is not pulsed.
  - abort beats a coincident step: sh_step is suppressed and counters do not advance.
  - abort in IDLE has no effect.
  - abort together with a start edge in IDLE: abort wins, the start is dropped.
- Width rules: step_cnt is 4 bits, prescaler is ceil(log2(TICK_DIV)) bits, and no counter wraps past its terminal value.

## Timing
- Reset (rst=0, asynchronous):
  - State IDLE.
  - cfg_len, sh_load, sh_step, lap_cnt, busy and done are 0.
  - prescaler, step_cnt and start_q are 0.
- Start edge sampled at edge N:
  - LOAD in cycle N+1: sh_load=1, busy=1.
  - RUN from N+2.
  - First sh_step in cycle N+2+TICK_DIV-1 when run_en is continuously 1.
- Consecutive sh_step pulses are exactly TICK_DIV enabled cycles apart.
- Uninterrupted run:
  - RUN lasts LAPS*STEPS_PER_LAP*TICK_DIV cycles, 128 with defaults.
  - done appears in the cycle after the final sh_step.
  - busy falls the cycle after done.
- Every pause cycle (run_en=0) delays all later events by exactly one cycle.
- sh_load and sh_step are never high in the same cycle.

## Test plan
- Reset then start pulse, defaults, run_en=1, switch=3:
  - sh_load in cycle N+1 with cfg_len=3.
  - 32 sh_step pulses, 4 cycles apart.
  - lap_cnt reaches 1 after step 16.
  - done at cycle N+2+128, busy=0 one cycle later.
- run_en=0 for 10 cycles mid-run:
  - No sh_step while paused.
  - done is delayed by exactly 10 cycles; total step count is still 32.
- abort raised in the cycle of step 20:
  - That sh_step is suppressed.
  - IDLE next cycle, no done, lap_cnt=1 held.
  - A new start edge clears the counters.
- Start re-pulsed and switch changed to 6 while busy: ignored, cfg_len stays 3, the run completes normally.
- rst driven low mid-run (between clock edges): all outputs are 0 immediately; with start held high, the first cycle after release starts a new run.
- start held high after a completed run: no second run until start goes low and then high again.

Source files
------------

// File: rtl/led_shift_sequencer.sv
// led_shift_sequencer: run controller that seeds the LED shifter, paces it with step pulses and counts laps.
module led_shift_sequencer #(
    parameter int TICK_DIV      = 4,
    parameter int STEPS_PER_LAP = 16,
    parameter int LAPS          = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       run_en,
    input  logic       abort,
    input  logic [2:0] switch,
    output logic [2:0] cfg_len,
    output logic       sh_load,
    output logic       sh_step,
    output logic [3:0] lap_cnt,
    output logic       busy,
    output logic       done
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic            start_q;
    logic [2:0]      cfg_q, cfg_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [3:0]      step_q, step_d;
    logic [3:0]      lap_q, lap_d;
    logic            start_edge, accept, advance, tick, lap_end, run_end;

    assign start_edge = start && !start_q;
    assign accept     = (state_q == IDLE) && start_edge && !abort;
    assign advance    = (state_q == RUN) && run_en && !abort;
    assign tick       = advance && (presc_q == PW'(TICK_DIV - 1));
    assign lap_end    = step_q == 4'(STEPS_PER_LAP - 1);
    assign run_end    = lap_end && (lap_q == 4'(LAPS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            cfg_q   <= '0;
            presc_q <= '0;
            step_q  <= '0;
            lap_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            cfg_q   <= cfg_d;
            presc_q <= presc_d;
            step_q  <= step_d;
            lap_q   <= lap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? LOAD : IDLE;
            LOAD:    state_d = abort ? IDLE : RUN;
            RUN:     state_d = abort ? IDLE : (tick && run_end) ? DONE : RUN;
            default: state_d = IDLE;
        endcase
    end

    // abort is folded into advance, so a coincident step never moves the counters
    always_comb begin
        cfg_d   = accept ? switch : cfg_q;
        presc_d = (accept || tick) ? '0 : advance ? presc_q + PW'(1) : presc_q;
        step_d  = accept ? 4'd0 : tick ? (lap_end ? 4'd0 : step_q + 4'd1) : step_q;
        lap_d   = accept ? 4'd0 : (tick && lap_end) ? lap_q + 4'd1 : lap_q;
    end

    always_comb begin
        sh_load = state_q == LOAD;
        sh_step = tick;
        busy    = state_q != IDLE;
        done    = state_q == DONE;
        cfg_len = cfg_q;
        lap_cnt = lap_q;
    end
endmodule

// File: tb/tb_led_shift_sequencer.sv
// tb_led_shift_sequencer: scenario tasks compared cycle by cycle against an enabled-cycle-count reference model.
module tb_led_shift_sequencer;
    localparam int TD = 4, SPL = 16, LAPS = 2;

    logic       clk = 0, rst = 0, start = 0, run_en = 0, abort = 0;
    logic [2:0] switch = 0;
    logic [2:0] cfg_len;
    logic       sh_load, sh_step, busy, done;
    logic [3:0] lap_cnt;

    int         checks = 0, failures = 0;
    int         m_ph = 0, m_en = 0;
    logic [2:0] m_cfg = 0;
    logic       m_prev = 0;
    logic [10:0] e_vec;
    wire  [10:0] o_vec = {cfg_len, sh_load, sh_step, lap_cnt, busy, done};

    led_shift_sequencer #(.TICK_DIV(TD), .STEPS_PER_LAP(SPL), .LAPS(LAPS)) dut (
        .clk(clk), .rst(rst), .start(start), .run_en(run_en), .abort(abort), .switch(switch),
        .cfg_len(cfg_len), .sh_load(sh_load), .sh_step(sh_step), .lap_cnt(lap_cnt),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // model: phase plus the number of enabled RUN cycles; steps and laps follow by division
    task automatic drv(input logic s, input logic r, input logic a, input logic [2:0] sw);
        start = s; run_en = r; abort = a; switch = sw;
        #1;
        e_vec = {m_cfg, m_ph == 1, m_ph == 2 && r && !a && (m_en % TD == TD - 1),
                 4'(m_en / (TD * SPL)), m_ph != 0, m_ph == 3};
    endtask

    task automatic adv();
        @(posedge clk);
        case (m_ph)
            0: if (start && !m_prev && !abort) begin m_ph = 1; m_cfg = switch; m_en = 0; end
            1: m_ph = abort ? 0 : 2;
            2: if (abort) m_ph = 0;
               else if (run_en) begin m_en++; if (m_en == TD * SPL * LAPS) m_ph = 3; end
            default: m_ph = 0;
        endcase
        m_prev = start;
        @(negedge clk);
    endtask

    task automatic test_reset();
        start = 1; run_en = 1; switch = 3'd7;
        repeat (2) begin
            @(negedge clk); #1;
            checks++;
            if (o_vec !== 11'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=000", o_vec); end
        end
        start = 0;
        rst = 1;
    endtask

    task automatic test_basic();
        int steps = 0, dcyc = -1;
        for (int i = 0; i < 135; i++) begin
            drv(i == 0, 1'b1, 1'b0, i == 0 ? 3'd3 : 3'($urandom));
            checks++;
            if (o_vec !== e_vec) begin failures++; $display("FAIL basic i=%0d got=%h exp=%h", i, o_vec, e_vec); end
            if (i == 1) begin
                checks++;
                if (sh_load !== 1'b1 || cfg_len !== 3'd3)
                    begin failures++; $display("FAIL basic_load got load=%b cfg=%0d exp load=1 cfg=3", sh_load, cfg_len); end
            end
            if (sh_step) steps++;
            if (done) dcyc = i;
            adv();
        end
        checks++;
        if (steps != 32 || dcyc != 130)
            begin failures++; $display("FAIL basic_timing got steps=%0d done_at=%0d exp 32/130", steps, dcyc); end
    endtask

    task automatic test_pause();
        int steps = 0, dcyc = -1;
        int p = $urandom_range(10, 100);
        for (int i = 0; i < 145; i++) begin
            drv(i == 0, !(i >= p && i < p + 10), 1'b0, 3'd3);
            checks++;
            if (o_vec !== e_vec) begin failures++; $display("FAIL pause i=%0d got=%h exp=%h", i, o_vec, e_vec); end
            if (sh_step) steps++;
            if (done) dcyc = i;
            adv();
        end
        checks++;
        if (steps != 32 || dcyc != 140)
            begin failures++; $display("FAIL pause_timing got steps=%0d done_at=%0d exp 32/140", steps, dcyc); end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 82; i++) begin
            drv(i == 0, 1'b1, i == 81, 3'd3);
            checks++;
            if (o_vec !== e_vec) begin failures++; $display("FAIL abort_run i=%0d got=%h exp=%h", i, o_vec, e_vec); end
            if (i == 81) begin
                checks++;
                if (sh_step !== 1'b0) begin failures++; $display("FAIL abort_step got=%b exp=0", sh_step); end
            end
            adv();
        end
        for (int i = 0; i < 4; i++) begin
            drv(1'b0, 1'b1, 1'b0, 3'd0);
            checks++;
            if (o_vec !== e_vec || busy !== 1'b0 || done !== 1'b0 || lap_cnt !== 4'd1)
                begin failures++; $display("FAIL abort_idle got=%h exp=%h lap=1", o_vec, e_vec); end
            adv();
        end
        drv(1'b1, 1'b1, 1'b0, 3'd2);
        checks++;
        if (o_vec !== e_vec) begin failures++; $display("FAIL restart_edge got=%h exp=%h", o_vec, e_vec); end
        adv();
        drv(1'b1, 1'b1, 1'b1, 3'd2);
        checks++;
        if (o_vec !== e_vec || lap_cnt !== 4'd0 || sh_load !== 1'b1)
            begin failures++; $display("FAIL restart_clear got=%h exp=%h", o_vec, e_vec); end
        adv();
        drv(1'b0, 1'b1, 1'b0, 3'd0);
        checks++;
        if (o_vec !== e_vec) begin failures++; $display("FAIL abort_load got=%h exp=%h", o_vec, e_vec); end
        adv();
        drv(1'b1, 1'b1, 1'b1, 3'd5);
        checks++;
        if (o_vec !== e_vec) begin failures++; $display("FAIL abort_start_a got=%h exp=%h", o_vec, e_vec); end
        adv();
        drv(1'b0, 1'b1, 1'b0, 3'd0);
        checks++;
        if (o_vec !== e_vec || busy !== 1'b0 || cfg_len !== 3'd2)
            begin failures++; $display("FAIL abort_start_b got=%h exp=%h", o_vec, e_vec); end
        adv();
    endtask

    task automatic test_busy_restart();
        int dcyc = -1;
        for (int i = 0; i < 135; i++) begin
            drv(i == 0 || i == 50, 1'b1, 1'b0, i == 0 ? 3'd3 : 3'd6);
            checks++;
            if (o_vec !== e_vec) begin failures++; $display("FAIL busy_restart i=%0d got=%h exp=%h", i, o_vec, e_vec); end
            if (done) dcyc = i;
            adv();
        end
        checks++;
        if (cfg_len !== 3'd3 || dcyc != 130)
            begin failures++; $display("FAIL busy_restart_end got cfg=%0d done_at=%0d exp 3/130", cfg_len, dcyc); end
    endtask

    task automatic test_async_reset();
        int dcyc = -1;
        for (int i = 0; i < 40; i++) begin
            drv(i == 0, 1'b1, 1'b0, 3'd1);
            checks++;
            if (o_vec !== e_vec) begin failures++; $display("FAIL pre_reset i=%0d got=%h exp=%h", i, o_vec, e_vec); end
            adv();
        end
        #2 rst = 0; start = 1;
        #1;
        checks++;
        if (o_vec !== 11'd0) begin failures++; $display("FAIL async_reset got=%h exp=000", o_vec); end
        m_ph = 0; m_en = 0; m_cfg = 0; m_prev = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 135; i++) begin
            drv(1'b1, 1'b1, 1'b0, 3'd4);
            checks++;
            if (o_vec !== e_vec) begin failures++; $display("FAIL post_reset i=%0d got=%h exp=%h", i, o_vec, e_vec); end
            if (done) dcyc = i;
            adv();
        end
        checks++;
        if (dcyc != 130) begin failures++; $display("FAIL post_reset_done got=%0d exp=130", dcyc); end
    endtask

    task automatic test_start_held();
        for (int i = 0; i < 20; i++) begin
            drv(1'b1, 1'b1, 1'b0, 3'd4);
            checks++;
            if (o_vec !== e_vec || busy !== 1'b0)
                begin failures++; $display("FAIL start_held i=%0d got=%h exp=%h", i, o_vec, e_vec); end
            adv();
        end
        drv(1'b0, 1'b1, 1'b0, 3'd6);
        checks++;
        if (o_vec !== e_vec) begin failures++; $display("FAIL held_low got=%h exp=%h", o_vec, e_vec); end
        adv();
        drv(1'b1, 1'b1, 1'b0, 3'd6);
        checks++;
        if (o_vec !== e_vec) begin failures++; $display("FAIL held_rise got=%h exp=%h", o_vec, e_vec); end
        adv();
        drv(1'b1, 1'b1, 1'b0, 3'd6);
        checks++;
        if (o_vec !== e_vec || sh_load !== 1'b1 || cfg_len !== 3'd6)
            begin failures++; $display("FAIL held_load got=%h exp=%h", o_vec, e_vec); end
        adv();
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 1'b1, i == 0, 3'd0);
            checks++;
            if (o_vec !== e_vec) begin failures++; $display("FAIL held_abort i=%0d got=%h exp=%h", i, o_vec, e_vec); end
            adv();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            drv($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 399) == 0, 3'($urandom));
            checks++;
            if (o_vec !== e_vec) begin failures++; $display("FAIL random i=%0d got=%h exp=%h", i, o_vec, e_vec); end
            adv();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_abort();
        test_busy_restart();
        test_async_reset();
        test_start_held();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
